// File: rtl/rbm_cdk_sequencer.sv
// rbm_cdk_sequencer: CD-k training sequencer that walks the per-frame
// V2H / H2V / UPD operation order and hands each one to the RBM engine.
//
// Ports:
//   ACLK, ARESET        clock, async active-high reset
//   soft_reset          synchronous abort and clear
//   start               job request, honoured only in IDLE
//   use_sampling        stochastic sampling enable (latched)
//   frame_len/i_dim/
//   h_dim/k_dim         job configuration (latched at start)
//   eng_op/eng_go/
//   eng_row/eng_sample  one-cycle operation request to the engine
//   eng_ack/eng_err     engine completion / fault
//   busy/done/error     job status; error is sticky
//   cur_frame           frame currently being processed
module rbm_cdk_sequencer #(
  parameter int TIMEOUT = 4096,
  parameter int MAX_DIM = 1024
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic        soft_reset,
  input  logic        start,
  input  logic        use_sampling,
  input  logic [15:0] frame_len,
  input  logic [15:0] i_dim,
  input  logic [15:0] h_dim,
  input  logic [7:0]  k_dim,
  output logic [1:0]  eng_op,
  output logic        eng_go,
  output logic [15:0] eng_row,
  output logic        eng_sample,
  input  logic        eng_ack,
  input  logic        eng_err,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] cur_frame
);

  localparam int TW =
    (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LAST =
    TW'(TIMEOUT - 1);
  localparam logic [16:0] MAX_D =
    17'(MAX_DIM);

  localparam logic [1:0] OP_V2H = 2'd0;
  localparam logic [1:0] OP_H2V = 2'd1;
  localparam logic [1:0] OP_UPD = 2'd2;

  typedef enum logic [1:0] {
    IDLE, ISSUE, WAIT, ERR
  } state_t;

  typedef enum logic [1:0] {
    POS, NEG_H2V, NEG_V2H, UPD
  } phase_t;

  state_t         state, state_nx;
  phase_t         phase;
  logic [15:0]    row;
  logic [7:0]     iter;
  logic [15:0]    frame;
  logic [TW-1:0]  wcnt;
  logic [15:0]    cfg_fl, cfg_i, cfg_h;
  logic [7:0]     cfg_k;
  logic           cfg_s;
  logic           done_q, err_q;

  logic cfg_ok;
  logic adv;
  logic row_last_h, row_last_i;
  logic iter_last, frame_last;

  always_comb begin
    cfg_ok = (frame_len != 16'd0)
          && (i_dim != 16'd0)
          && (h_dim != 16'd0)
          && ({1'b0, i_dim} <= MAX_D)
          && ({1'b0, h_dim} <= MAX_D);
    row_last_h = (row == cfg_h - 16'd1);
    row_last_i = (row == cfg_i - 16'd1);
    iter_last  = (iter == cfg_k - 8'd1);
    frame_last = (frame == cfg_fl - 16'd1);
    // eng_err beats a same-cycle eng_ack
    adv = (state == WAIT) && eng_ack && !eng_err;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start)
          state_nx = cfg_ok ? ISSUE : ERR;
      end
      ISSUE: state_nx = WAIT;
      WAIT: begin
        if (eng_err)
          state_nx = ERR;
        else if (eng_ack)
          state_nx = (phase == UPD && frame_last)
                   ? IDLE : ISSUE;
        else if (wcnt == T_LAST)
          state_nx = ERR;
      end
      ERR: state_nx = IDLE;
    endcase
    if (soft_reset)
      state_nx = IDLE;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state  <= IDLE;
      phase  <= POS;
      row    <= '0;
      iter   <= '0;
      frame  <= '0;
      wcnt   <= '0;
      cfg_fl <= '0;
      cfg_i  <= '0;
      cfg_h  <= '0;
      cfg_k  <= '0;
      cfg_s  <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else if (soft_reset) begin
      state  <= IDLE;
      phase  <= POS;
      row    <= '0;
      iter   <= '0;
      frame  <= '0;
      wcnt   <= '0;
      cfg_fl <= '0;
      cfg_i  <= '0;
      cfg_h  <= '0;
      cfg_k  <= '0;
      cfg_s  <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_nx;
      done_q <= 1'b0;

      if (state == IDLE && start) begin
        cfg_fl <= frame_len;
        cfg_i  <= i_dim;
        cfg_h  <= h_dim;
        cfg_k  <= k_dim;
        cfg_s  <= use_sampling;
        phase  <= POS;
        row    <= '0;
        iter   <= '0;
        frame  <= '0;
        err_q  <= !cfg_ok;
      end

      if (state == ISSUE)
        wcnt <= '0;
      else if (state == WAIT)
        wcnt <= wcnt + TW'(1);

      if (state_nx == ERR)
        err_q <= 1'b1;

      if (adv) begin
        unique case (phase)
          POS: begin
            if (row_last_h) begin
              row  <= '0;
              iter <= '0;
              phase <= (cfg_k == 8'd0)
                     ? UPD : NEG_H2V;
            end else begin
              row <= row + 16'd1;
            end
          end
          NEG_H2V: begin
            if (row_last_i) begin
              row   <= '0;
              phase <= NEG_V2H;
            end else begin
              row <= row + 16'd1;
            end
          end
          NEG_V2H: begin
            if (row_last_h) begin
              row <= '0;
              if (iter_last) begin
                phase <= UPD;
              end else begin
                iter  <= iter + 8'd1;
                phase <= NEG_H2V;
              end
            end else begin
              row <= row + 16'd1;
            end
          end
          UPD: begin
            frame <= frame + 16'd1;
            phase <= POS;
            row   <= '0;
            if (frame_last)
              done_q <= 1'b1;
          end
        endcase
      end
    end
  end

  always_comb begin
    eng_op = OP_V2H;
    unique case (phase)
      POS:     eng_op = OP_V2H;
      NEG_H2V: eng_op = OP_H2V;
      NEG_V2H: eng_op = OP_V2H;
      UPD:     eng_op = OP_UPD;
    endcase
  end

  assign eng_go     = (state == ISSUE);
  assign busy       = (state == ISSUE)
                   || (state == WAIT);
  assign eng_row    = row;
  assign eng_sample = busy && cfg_s
                   && (phase != UPD);
  assign done       = done_q;
  assign error      = err_q;
  assign cur_frame  = frame;

endmodule
